// File: rtl/nmcu_tile_engine.sv
// nmcu_tile_engine: near-memory tile engine. Fetches one HxW activation tile
// from memory (pitched rows), buffers it locally, applies PASS / RELU /
// 2x2 MAXPOOL and writes the result tile back with its own pitch.
//
// Ports:
//   clk, rst (async, active-high)
//   start, op, in_addr, in_pitch, out_addr, out_pitch, tile_w, tile_h : command
//   busy, done, err                                                    : status
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready         : memory port
//   stall_cycles : only when NMCU_STALL_CNT_EN is defined; counts cycles
//                  with mem_req=1 and mem_ready=0 (saturating, cleared on start)
module nmcu_tile_engine #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_DIM  = 16,
  localparam int unsigned DIM_W   = $clog2(MAX_DIM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_pitch,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic [ADDR_W-1:0] out_pitch,
  input  logic [DIM_W-1:0]  tile_w,
  input  logic [DIM_W-1:0]  tile_h,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef NMCU_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned BUF_DEPTH = MAX_DIM * MAX_DIM;
  localparam int unsigned BUF_AW    = $clog2(BUF_DEPTH);

  localparam logic [1:0] OP_PASS  = 2'd0;
  localparam logic [1:0] OP_RELU  = 2'd1;
  localparam logic [1:0] OP_MAXP2 = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_REJECT,
    S_FINISH
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  in_pitch_q;
  logic [ADDR_W-1:0]  out_addr_q;
  logic [ADDR_W-1:0]  out_pitch_q;
  logic [ADDR_W-1:0]  row_base;
  logic [DIM_W-1:0]   tile_w_q;
  logic [DIM_W-1:0]   tile_h_q;
  logic [DIM_W-1:0]   out_w_q;
  logic [DIM_W-1:0]   out_h_q;
  logic [DIM_W-1:0]   rd_r;
  logic [DIM_W-1:0]   rd_c;
  logic [DIM_W-1:0]   wr_r;
  logic [DIM_W-1:0]   wr_c;
  logic [DATA_W-1:0]  buffer [BUF_DEPTH];

  logic               xfer_c;
  logic               dims_bad_c;
  logic [BUF_AW-1:0]  rd_idx_c;
  logic [DIM_W:0]     src_r_c;
  logic [DIM_W:0]     src_c_c;
  logic [BUF_AW-1:0]  idx00_c;
  logic [BUF_AW-1:0]  idx10_c;
  logic signed [DATA_W-1:0] v00_c, v01_c, v10_c, v11_c, max_top_c, max_bot_c;

  assign xfer_c = mem_req & mem_ready;

  // Command validation on the raw inputs, evaluated in the start cycle
  always_comb begin
    dims_bad_c = 1'b0;
    if (tile_w == '0 || 32'(tile_w) > MAX_DIM) dims_bad_c = 1'b1;
    if (tile_h == '0 || 32'(tile_h) > MAX_DIM) dims_bad_c = 1'b1;
    if (op == OP_RSVD) dims_bad_c = 1'b1;
    if (op == OP_MAXP2 && (tile_w < DIM_W'(2) || tile_h < DIM_W'(2))) dims_bad_c = 1'b1;
  end

  // Buffer is row-major with a fixed MAX_DIM row stride
  assign rd_idx_c = BUF_AW'(rd_r) * BUF_AW'(MAX_DIM) + BUF_AW'(rd_c);

  always_ff @(posedge clk) begin
    if (state == S_LOAD && xfer_c) buffer[rd_idx_c] <= mem_rdata;
  end

  // Write data straight from the buffer; maxpool reads the 2x2 window at (2r,2c)
  always_comb begin
    src_r_c   = (op_q == OP_MAXP2) ? {wr_r, 1'b0} : {1'b0, wr_r};
    src_c_c   = (op_q == OP_MAXP2) ? {wr_c, 1'b0} : {1'b0, wr_c};
    idx00_c   = BUF_AW'(src_r_c) * BUF_AW'(MAX_DIM) + BUF_AW'(src_c_c);
    idx10_c   = idx00_c + BUF_AW'(MAX_DIM);
    v00_c     = buffer[idx00_c];
    v01_c     = buffer[idx00_c + BUF_AW'(1)];
    v10_c     = buffer[idx10_c];
    v11_c     = buffer[idx10_c + BUF_AW'(1)];
    max_top_c = (v00_c > v01_c) ? v00_c : v01_c;
    max_bot_c = (v10_c > v11_c) ? v10_c : v11_c;
    mem_wdata = '0;
    if (state == S_STORE) begin
      case (op_q)
        OP_RELU:  mem_wdata = v00_c[DATA_W-1] ? '0 : v00_c;
        OP_MAXP2: mem_wdata = (max_top_c > max_bot_c) ? max_top_c : max_bot_c;
        default:  mem_wdata = v00_c;
      endcase
    end
  end

  // Control FSM with registered outputs and incremental row-base addressing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      op_q        <= OP_PASS;
      in_pitch_q  <= '0;
      out_addr_q  <= '0;
      out_pitch_q <= '0;
      row_base    <= '0;
      tile_w_q    <= '0;
      tile_h_q    <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      rd_r        <= '0;
      rd_c        <= '0;
      wr_r        <= '0;
      wr_c        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q        <= op;
            in_pitch_q  <= in_pitch;
            out_addr_q  <= out_addr;
            out_pitch_q <= out_pitch;
            tile_w_q    <= tile_w;
            tile_h_q    <= tile_h;
            out_w_q     <= (op == OP_MAXP2) ? (tile_w >> 1) : tile_w;
            out_h_q     <= (op == OP_MAXP2) ? (tile_h >> 1) : tile_h;
            err         <= 1'b0;
            busy        <= 1'b1;
            rd_r        <= '0;
            rd_c        <= '0;
            if (dims_bad_c) begin
              state <= S_REJECT;
            end else begin
              state    <= S_LOAD;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= in_addr;
              row_base <= in_addr;
            end
          end
        end
        S_LOAD: begin
          if (xfer_c) begin
            if (rd_c == tile_w_q - DIM_W'(1)) begin
              rd_c <= '0;
              if (rd_r == tile_h_q - DIM_W'(1)) begin
                state    <= S_STORE;
                mem_we   <= 1'b1;
                mem_addr <= out_addr_q;
                row_base <= out_addr_q;
                wr_r     <= '0;
                wr_c     <= '0;
              end else begin
                rd_r     <= rd_r + DIM_W'(1);
                row_base <= row_base + in_pitch_q;
                mem_addr <= row_base + in_pitch_q;
              end
            end else begin
              rd_c     <= rd_c + DIM_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        S_STORE: begin
          if (xfer_c) begin
            if (wr_c == out_w_q - DIM_W'(1)) begin
              wr_c <= '0;
              if (wr_r == out_h_q - DIM_W'(1)) begin
                state    <= S_FINISH;
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= '0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                wr_r     <= wr_r + DIM_W'(1);
                row_base <= row_base + out_pitch_q;
                mem_addr <= row_base + out_pitch_q;
              end
            end else begin
              wr_c     <= wr_c + DIM_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        S_REJECT: begin
          state <= S_FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= 1'b1;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef NMCU_STALL_CNT_EN
  // Saturating count of stalled request cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cycles <= '0;
    end else if (mem_req && !mem_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nmcu_tile_engine.sv
// Testbench for nmcu_tile_engine: memory model, randomized ready/data and a
// reference model of the tile operations built from plain loops.
module tb_nmcu_tile_engine;
  localparam int LIMIT = 5000;

  logic        clk, rst, start, busy, done, err;
  logic [1:0]  op;
  logic [15:0] in_addr, in_pitch, out_addr, out_pitch, mem_addr;
  logic [4:0]  tile_w, tile_h;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef NMCU_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic [31:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  // Results of the last run_op
  int          done_cycle, busy_bad, stab_bad, req_seen, tb_stalls;
  logic        err_at_done, busy_at_done, rst_req, rst_busy;
  logic [15:0] rd_q[$], wa_q[$];
  logic [31:0] wd_q[$];
  logic [15:0] exp_rd[$], exp_wa[$];
  logic [31:0] exp_wd[$];

  nmcu_tile_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .in_addr(in_addr), .in_pitch(in_pitch), .out_addr(out_addr), .out_pitch(out_pitch),
    .tile_w(tile_w), .tile_h(tile_h), .busy(busy), .done(done), .err(err),
`ifdef NMCU_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one command and logs every memory transfer. mode: 0 ready high,
  // 1 three-cycle stall on every 2nd transfer, 2 random ready.
  task automatic run_op(input logic [1:0] t_op, input logic [15:0] t_ia, t_ip, t_oa, t_opitch,
                        input int w, h, mode, abort_writes);
    int cycle = 0, xfers = 0, stall_run = 0;
    logic pend = 1'b0, p_we = 1'b0, aborted = 1'b0;
    logic [15:0] p_addr = '0;
    logic [31:0] p_wdata = '0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    done_cycle = -1; busy_bad = 0; stab_bad = 0; req_seen = 0; tb_stalls = 0;
    @(negedge clk);
    op = t_op; in_addr = t_ia; in_pitch = t_ip; out_addr = t_oa; out_pitch = t_opitch;
    tile_w = 5'(w); tile_h = 5'(h); start = 1'b1; mem_ready = 1'b1;
    while (cycle < LIMIT) begin
      @(negedge clk);
      start = 1'b0;
      cycle++;
      if (mem_req) req_seen++;
      if (done) begin
        done_cycle = cycle; err_at_done = err; busy_at_done = busy;
        break;
      end
      if (!busy) busy_bad++;
      if (abort_writes >= 0 && wa_q.size() == abort_writes) begin
        rst = 1'b1;
        #1;
        rst_req = mem_req; rst_busy = busy; aborted = 1'b1;
        break;
      end
      if (pend && (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
                   (p_we && mem_wdata !== p_wdata))) stab_bad++;
      case (mode)
        1:       mem_ready = !(mem_req && (xfers % 2 == 1) && stall_run < 3);
        2:       mem_ready = ($urandom_range(0, 3) != 0);
        default: mem_ready = 1'b1;
      endcase
      if (mode == 1 && !mem_ready) stall_run++;
      pend = mem_req && !mem_ready;
      if (pend) begin
        tb_stalls++; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
        else rd_q.push_back(mem_addr);
        xfers++; stall_run = 0;
      end
    end
    mem_ready = 1'b1;
    if (!aborted) begin
      checks++;
      if (done_cycle < 0) begin
        errors++;
        $display("FAIL timeout: no done within %0d cycles (op=%0d %0dx%0d)", LIMIT, t_op, h, w);
      end
    end
  endtask

  // Reference: expected read addresses and (addr,data) writes from the tile rules
  task automatic build_model(input logic [1:0] t_op, input logic [15:0] t_ia, t_ip, t_oa, t_opitch,
                             input int w, h);
    int t [16][16];
    int m, v;
    logic [15:0] a;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        a = 16'(32'(t_ia) + 32'(r) * 32'(t_ip) + 32'(c));
        exp_rd.push_back(a);
        t[r][c] = $signed(mem[a]);
      end
    if (t_op == 2'd2) begin
      for (int r = 0; r < h / 2; r++)
        for (int c = 0; c < w / 2; c++) begin
          m = t[2*r][2*c];
          if (t[2*r][2*c+1] > m) m = t[2*r][2*c+1];
          if (t[2*r+1][2*c] > m) m = t[2*r+1][2*c];
          if (t[2*r+1][2*c+1] > m) m = t[2*r+1][2*c+1];
          exp_wa.push_back(16'(32'(t_oa) + 32'(r) * 32'(t_opitch) + 32'(c)));
          exp_wd.push_back(32'(m));
        end
    end else begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          v = t[r][c];
          if (t_op == 2'd1 && v < 0) v = 0;
          exp_wa.push_back(16'(32'(t_oa) + 32'(r) * 32'(t_opitch) + 32'(c)));
          exp_wd.push_back(32'(v));
        end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b req=%b we=%b addr=%h wdata=%h, all expected 0",
               busy, done, err, mem_req, mem_we, mem_addr, mem_wdata);
    end
`ifdef NMCU_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b req=%b expected 0/0", busy, mem_req);
    end
  endtask

  task automatic test_pass();
    logic [15:0] ra [6] = '{16'h10, 16'h11, 16'h12, 16'h15, 16'h16, 16'h17};
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    run_op(2'd0, 16'h10, 16'd5, 16'h40, 16'd3, 3, 2, 0, -1);
    checks++;
    if (done_cycle != 13 || err_at_done !== 1'b0 || busy_at_done !== 1'b0 || busy_bad != 0) begin
      errors++;
      $display("FAIL pass_timing: done_cycle=%0d err=%b busy@done=%b busy_gaps=%0d expected 13/0/0/0",
               done_cycle, err_at_done, busy_at_done, busy_bad);
    end
    checks++;
    if (rd_q.size() != 6 || wa_q.size() != 6) begin
      errors++; $display("FAIL pass_counts: reads=%0d writes=%0d expected 6/6", rd_q.size(), wa_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rd_q[i] !== ra[i] || wa_q[i] !== 16'h40 + 16'(i) || wd_q[i] !== 32'(ra[i])) begin
          errors++;
          $display("FAIL pass_xfer[%0d]: rd=%h wa=%h wd=%h expected %h/%h/%h",
                   i, rd_q[i], wa_q[i], wd_q[i], ra[i], 16'h40 + 16'(i), 32'(ra[i]));
        end
      end
    end
  endtask

  task automatic test_relu();
    logic [31:0] ev [4] = '{32'd0, 32'd3, 32'd0, 32'd0};
    mem[16'h200] = 32'hFFFF_FFFB; mem[16'h201] = 32'd3;
    mem[16'h202] = 32'd0;         mem[16'h203] = 32'hFFFF_FFFF;
    run_op(2'd1, 16'h200, 16'd7, 16'h300, 16'd1, 4, 1, 0, -1);
    checks++;
    if (done_cycle != 9 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL relu_done: cycle=%0d err=%b expected 9/0", done_cycle, err_at_done);
    end
    checks++;
    if (wa_q.size() != 4) begin
      errors++; $display("FAIL relu_count: writes=%0d expected 4", wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa_q[i] !== 16'h300 + 16'(i) || wd_q[i] !== ev[i]) begin
          errors++;
          $display("FAIL relu_write[%0d]: addr=%h data=%h expected %h/%h",
                   i, wa_q[i], wd_q[i], 16'h300 + 16'(i), ev[i]);
        end
      end
    end
  endtask

  task automatic test_maxpool();
    logic [31:0] ev [4] = '{32'd6, 32'd8, 32'd16, 32'd18};
    logic [15:0] ea [4] = '{16'h500, 16'h501, 16'h502, 16'h503};
    for (int i = 0; i < 25; i++) mem[16'h100 + 16'(i)] = 32'(i);
    mem[16'h10B] = 32'hFFFF_FF9C;
    run_op(2'd2, 16'h100, 16'd5, 16'h500, 16'd2, 5, 5, 0, -1);
    checks++;
    if (rd_q.size() != 25 || wa_q.size() != 4 || done_cycle != 30) begin
      errors++;
      $display("FAIL maxp_counts: reads=%0d writes=%0d done=%0d expected 25/4/30",
               rd_q.size(), wa_q.size(), done_cycle);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa_q[i] !== ea[i] || wd_q[i] !== ev[i]) begin
          errors++;
          $display("FAIL maxp_write[%0d]: addr=%h data=%0d expected %h/%0d",
                   i, wa_q[i], $signed(wd_q[i]), ea[i], ev[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    int eo [4] = '{0, 3, 2, 0};
    int ew [4] = '{0, 2, 4, 17};
    int eh [4] = '{3, 2, 1, 2};
    for (int i = 0; i < 4; i++) begin
      run_op(2'(eo[i]), 16'h20, 16'd4, 16'h60, 16'd4, ew[i], eh[i], 0, -1);
      checks++;
      if (done_cycle != 2 || err_at_done !== 1'b1 || req_seen != 0) begin
        errors++;
        $display("FAIL err_case%0d: done=%0d err=%b req_cycles=%0d expected 2/1/0",
                 i, done_cycle, err_at_done, req_seen);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL err_hold%0d: err=%b done=%b expected 1/0", i, err, done);
      end
    end
  endtask

  task automatic test_stalls();
    run_op(2'd0, 16'h700, 16'd9, 16'h780, 16'd4, 2, 2, 1, -1);
    build_model(2'd0, 16'h700, 16'd9, 16'h780, 16'd4, 2, 2);
    checks++;
    if (done_cycle != 21 || stab_bad != 0) begin
      errors++;
      $display("FAIL stall_timing: done=%0d unstable=%0d expected 21/0", done_cycle, stab_bad);
    end
    checks++;
    if (wa_q.size() != exp_wa.size() || wa_q != exp_wa || wd_q != exp_wd || rd_q != exp_rd) begin
      errors++;
      $display("FAIL stall_data: writes=%0d expected %0d or contents differ", wa_q.size(), exp_wa.size());
    end
`ifdef NMCU_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd12) begin
      errors++; $display("FAIL stall_cnt: got %0d expected 12", stall_cycles);
    end
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd12) begin
      errors++; $display("FAIL stall_cnt_hold: got %0d expected 12", stall_cycles);
    end
`endif
  endtask

  task automatic test_reset_mid_store();
    int bad = 0;
    run_op(2'd0, 16'h800, 16'd3, 16'h900, 16'd3, 3, 3, 0, 2);
    checks++;
    if (rst_req !== 1'b0 || rst_busy !== 1'b0 || wa_q.size() != 2) begin
      errors++;
      $display("FAIL reset_store: req=%b busy=%b writes=%0d expected 0/0/2", rst_req, rst_busy, wa_q.size());
    end
    repeat (2) begin @(negedge clk); if (done || mem_req) bad++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (done || mem_req || busy) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_no_done: %0d bad cycles expected 0", bad);
    end
    run_op(2'd0, 16'h800, 16'd3, 16'h900, 16'd3, 3, 3, 0, -1);
    build_model(2'd0, 16'h800, 16'd3, 16'h900, 16'd3, 3, 3);
    checks++;
    if (done_cycle != 19 || err_at_done !== 1'b0 || wa_q != exp_wa || wd_q != exp_wd || rd_q != exp_rd) begin
      errors++;
      $display("FAIL reset_rerun: done=%0d err=%b writes=%0d expected 19/0/%0d",
               done_cycle, err_at_done, wa_q.size(), exp_wa.size());
    end
  endtask

  task automatic test_back_to_back();
    run_op(2'd1, 16'hA00, 16'd2, 16'hA80, 16'd2, 2, 2, 0, -1);
    build_model(2'd1, 16'hA00, 16'd2, 16'hA80, 16'd2, 2, 2);
    checks++;
    if (done_cycle != 9 || wa_q != exp_wa || wd_q != exp_wd) begin
      errors++; $display("FAIL b2b_first: done=%0d expected 9 or data differs", done_cycle);
    end
    // Next command is raised in the cycle right after done
    run_op(2'd2, 16'hB00, 16'd4, 16'hB80, 16'd1, 4, 2, 0, -1);
    build_model(2'd2, 16'hB00, 16'd4, 16'hB80, 16'd1, 4, 2);
    checks++;
    if (done_cycle != 11 || wa_q != exp_wa || wd_q != exp_wd || rd_q != exp_rd) begin
      errors++; $display("FAIL b2b_second: done=%0d expected 11 or data differs", done_cycle);
    end
    // Start during the done cycle must be dropped
    op = 2'd0; tile_w = 5'd2; tile_h = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL finish_start_ignored: busy=%b req=%b expected 0/0", busy, mem_req);
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] ia, ip, oa, opit;
    int w, h;
    for (int it = 0; it < 20; it++) begin
      o    = 2'($urandom_range(0, 2));
      w    = (o == 2'd2) ? $urandom_range(2, 16) : $urandom_range(1, 16);
      h    = (o == 2'd2) ? $urandom_range(2, 16) : $urandom_range(1, 16);
      ia   = (it == 0) ? 16'hFFFA : 16'($urandom);
      ip   = 16'($urandom_range(0, 40));
      oa   = (it == 1) ? 16'hFFFE : 16'($urandom);
      opit = 16'($urandom_range(0, 40));
      run_op(o, ia, ip, oa, opit, w, h, 2, -1);
      build_model(o, ia, ip, oa, opit, w, h);
      checks++;
      if (done_cycle != 1 + exp_rd.size() + exp_wa.size() + tb_stalls || err_at_done !== 1'b0 || stab_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_ctrl: done=%0d err=%b unstable=%0d expected %0d/0/0", it, done_cycle,
                 err_at_done, stab_bad, 1 + exp_rd.size() + exp_wa.size() + tb_stalls);
      end
      checks++;
      if (rd_q.size() != exp_rd.size() || wa_q.size() != exp_wa.size()) begin
        errors++;
        $display("FAIL rand%0d_counts: reads=%0d writes=%0d expected %0d/%0d",
                 it, rd_q.size(), wa_q.size(), exp_rd.size(), exp_wa.size());
      end else begin
        foreach (rd_q[i]) begin
          checks++;
          if (rd_q[i] !== exp_rd[i]) begin
            errors++; $display("FAIL rand%0d_rd[%0d]: addr=%h expected %h", it, i, rd_q[i], exp_rd[i]);
          end
        end
        foreach (wa_q[i]) begin
          checks++;
          if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
            errors++;
            $display("FAIL rand%0d_wr[%0d]: addr=%h data=%h expected %h/%h",
                     it, i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; in_addr = '0; in_pitch = '0;
    out_addr = '0; out_pitch = '0; tile_w = '0; tile_h = '0; mem_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    test_reset();
    test_pass();
    test_relu();
    test_maxpool();
    test_errors();
    test_stalls();
    test_reset_mid_store();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
